// File: rtl/tick_slot_arbiter.sv
// Round-robin arbiter with tick-bounded grant slots.
// A free-running prescaler paces the slot timer; expiry forces a handover.
module tick_slot_arbiter #(
    parameter int N        = 4,
    parameter int PRESCALE = 16,
    parameter int SLOT     = 8,
    parameter int W_N      = $clog2(N),
    parameter int W_S      = $clog2(SLOT + 1)
) (
    input  logic           iCLK,
    input  logic           iRESET_N,
    input  logic           iEN,
    input  logic [N-1:0]   iREQ,
    output logic [N-1:0]   oGNT,
    output logic [W_N-1:0] oGNT_ID,
    output logic           oBUSY,
    output logic           oTIMEOUT,
    output logic           oTICK
);

    localparam int W_P = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GUARD
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [W_P-1:0] pre;
    logic [W_S-1:0] slot_cnt;
    logic [W_N-1:0] ptr;
    logic [W_N-1:0] owner;
    logic [W_N-1:0] owner_d;
    logic [W_N-1:0] pick;
    logic [N-1:0]   gnt;
    logic [W_N-1:0] gnt_id;
    logic           timeout;
    logic           load;
    logic           to_guard;
    logic           expire;
    logic           found;

    assign oTICK    = iEN && (pre == W_P'(PRESCALE - 1));
    assign oGNT     = gnt;
    assign oGNT_ID  = gnt_id;
    assign oBUSY    = (state == GRANT);
    assign oTIMEOUT = timeout;

    // Free-running prescaler; only iEN gates it.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            pre <= '0;
        end else if (iEN) begin
            pre <= (pre == W_P'(PRESCALE - 1)) ? '0 : pre + 1'b1;
        end
    end

    // Round-robin pick: first request above ptr, wrapping.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && iREQ[(int'(ptr) + i) % N]) begin
                pick  = W_N'((int'(ptr) + i) % N);
                found = 1'b1;
            end
        end
    end

    // Next-state logic; a release wins over a coincident expiry.
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        to_guard = 1'b0;
        expire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|iREQ) begin
                    state_d = GRANT;
                    load    = 1'b1;
                end
            end
            GRANT: begin
                if (!iREQ[owner]) begin
                    state_d  = GUARD;
                    to_guard = 1'b1;
                end else if (oTICK && slot_cnt == W_S'(SLOT - 1)) begin
                    state_d  = GUARD;
                    to_guard = 1'b1;
                    expire   = 1'b1;
                end
            end
            GUARD: begin
                if (|iREQ) begin
                    state_d = GRANT;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        owner_d = load ? pick : owner;
    end

    // State register.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Owner, pointer, slot timer and registered outputs.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            owner    <= '0;
            ptr      <= W_N'(N - 1);
            slot_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
        end else begin
            owner   <= owner_d;
            timeout <= expire;
            gnt     <= (state_d == GRANT) ? (ONE << owner_d) : '0;
            gnt_id  <= (state_d == GRANT) ? owner_d : '0;
            if (to_guard) begin
                ptr <= owner;
            end
            if (load) begin
                slot_cnt <= '0;
            end else if (state == GRANT && oTICK) begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_slot_arbiter.sv
// Bench for tick_slot_arbiter: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tick_slot_arbiter;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int SL = 3;
    localparam int WN = $clog2(N);

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [WN-1:0] gnt_id;
    logic          busy;
    logic          tmo;
    logic          tick;

    int errors;
    int checks;

    tick_slot_arbiter #(.N(N), .PRESCALE(P), .SLOT(SL)) dut (
        .iCLK     (clk),
        .iRESET_N (rst_n),
        .iEN      (en),
        .iREQ     (req),
        .oGNT     (gnt),
        .oGNT_ID  (gnt_id),
        .oBUSY    (busy),
        .oTIMEOUT (tmo),
        .oTICK    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner = -1 means no grant this cycle.
    int m_pre;
    int m_owner;
    int m_last;
    int m_used;
    bit m_to;
    bit m_tk;

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // Model advances on the same edge as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre   = 0;
            m_owner = -1;
            m_last  = N - 1;
            m_used  = 0;
            m_to    = 0;
        end else begin
            m_tk = en && (m_pre == P - 1);
            m_to = 0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else if (m_tk && m_used == SL - 1) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_to    = 1;
                end else if (m_tk) begin
                    m_used++;
                end
            end else if (req != 0) begin
                m_owner = rr_pick(m_last, req);
                m_used  = 0;
            end
            if (en) m_pre = (m_pre + 1) % P;
        end
    end

    // Compare all outputs against the model every cycle.
    always @(negedge clk) begin
        check("gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
        check("gnt_id", int'(gnt_id), (m_owner >= 0) ? m_owner : 0);
        check("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        check("timeout", int'(tmo), int'(m_to));
        check("tick", int'(tick), (en && m_pre == P - 1) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        req = '0;
        en  = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string name, output int id);
        int k;
        id = -1;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (gnt != 0) begin
                id = int'(gnt_id);
                break;
            end
        end
        if (id < 0) check({name, "_wait"}, 0, 1);
    endtask

    task automatic wait_free(input string name);
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (gnt == 0) break;
        end
        if (k == 30) check({name, "_wait"}, 0, 1);
    endtask

    task automatic wait_tick(input string name);
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tick) break;
        end
        if (k == 30) check({name, "_wait"}, 0, 1);
    endtask

    int ids[5];
    int id;
    int len;
    int bad;
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_fx[3] = '{0, 1, 0};

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        req    = '0;

        // Held in reset with all requests: no grant.
        req = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_first", int'(gnt), 4'b0001);

        // Round robin with frozen timer.
        do_reset();
        en  = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr", ids[k]);
            check("rr_order", ids[k], exp_rr[k]);
            cyc(3);
            if (ids[k] >= 0) req[ids[k]] = 1'b0;
            cyc(1);
            req = 4'b1111;
        end

        // Timeout of a sole requester aligned so the grant spans 6 cycles.
        do_reset();
        wait_tick("to_align");
        #1 req = 4'b0100;
        wait_gnt("to", id);
        check("to_owner", id, 2);
        len = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt != 4'b0100) break;
            len++;
        end
        check("to_len", len, 6);
        check("to_gap", int'(gnt), 0);
        check("to_pulse", int'(tmo), 1);
        @(negedge clk);
        check("to_regrant", int'(gnt), 4'b0100);
        check("to_once", int'(tmo), 0);

        // Release on the final tick counts as a release.
        #1 req = '0;
        cyc(4);
        wait_tick("sim_align");
        #1 req = 4'b0100;
        wait_gnt("sim", id);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        check("sim_tick", int'(tick), 1);
        check("sim_held", int'(gnt), 4'b0100);
        @(negedge clk);
        check("sim_gap", int'(gnt), 0);
        check("sim_no_to", int'(tmo), 0);

        // Two requesters alternate on expiry.
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            wait_gnt("fx", id);
            check("fx_order", id, exp_fx[k]);
            wait_free("fx");
            check("fx_pulse", int'(tmo), 1);
        end

        // Freeze mid-grant, then asynchronous reset mid-grant.
        do_reset();
        req = 4'b0001;
        wait_gnt("frz", id);
        #1 en = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tick || gnt != 4'b0001) bad++;
        end
        check("frz_hold", bad, 0);
        req = 4'b0011;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt", int'(gnt), 0);
        check("arst_busy", int'(busy), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        en = 1'b1;
        wait_gnt("arst", id);
        check("arst_ptr", id, 0);

        // Randomised traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
